// File: rtl/huffman_decoder.sv
// Bit-serial canonical Huffman decoder: rebuilds the canonical codebook from
// per-symbol code lengths, then decodes `length` bits into 4-bit symbols.
module huffman_decoder #(
  parameter int MAX_LEN = 15,
  parameter int LEN_W   = 11
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             tbl_we,
  input  logic [3:0]       tbl_sym,
  input  logic [3:0]       tbl_len,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [3:0]       sym_out,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [LEN_W-1:0] sym_count,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both 1; the producer holds data and valid stable until that edge.

  localparam int CW = MAX_LEN + 1;
  localparam logic [4:0] MAX_LEN_5 = 5'(MAX_LEN);
  localparam logic [3:0] MAX_LEN_4 = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUILD  = 3'd1,
    S_DECODE = 3'd2,
    S_EMIT   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t           state_q;
  logic [3:0]       len_q    [16];
  logic [3:0]       sorted_q [16];
  logic [4:0]       cnt_q    [MAX_LEN+1];
  logic [3:0]       sort_n_q;
  logic [3:0]       bl_q;
  logic [3:0]       bs_q;
  logic [LEN_W-1:0] bits_left_q;
  logic [CW-1:0]    code_q;
  logic [CW-1:0]    first_q;
  logic [3:0]       index_q;
  logic [3:0]       cur_len_q;
  logic [3:0]       sym_out_q;
  logic [LEN_W-1:0] sym_count_q;
  logic             err_q;

  logic [CW-1:0]    code_d;
  logic [3:0]       cur_len_d;
  logic [4:0]       cnt_cur;
  logic [CW-1:0]    diff;
  logic             hit;
  logic [3:0]       sel;
  logic [LEN_W-1:0] bits_left_d;

  always_comb begin
    code_d      = code_q | CW'(bit_in);
    cur_len_d   = cur_len_q + 4'd1;
    cnt_cur     = cnt_q[cur_len_d];
    diff        = code_d - first_q;
    hit         = diff < CW'(cnt_cur);
    sel         = index_q + diff[3:0];
    bits_left_d = bits_left_q - LEN_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 16; i++) begin
        len_q[i]    <= '0;
        sorted_q[i] <= '0;
      end
      for (int i = 0; i <= MAX_LEN; i++) cnt_q[i] <= '0;
      sort_n_q    <= '0;
      bl_q        <= '0;
      bs_q        <= '0;
      bits_left_q <= '0;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      cur_len_q   <= '0;
      sym_out_q   <= '0;
      sym_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tbl_we)
            len_q[tbl_sym] <= ({1'b0, tbl_len} > MAX_LEN_5) ? 4'd0 : tbl_len;
          if (start) begin
            bits_left_q <= length;
            sym_count_q <= '0;
            err_q       <= 1'b0;
            bl_q        <= 4'd1;
            bs_q        <= 4'd0;
            sort_n_q    <= 4'd0;
            for (int i = 0; i <= MAX_LEN; i++) cnt_q[i] <= '0;
            state_q     <= S_BUILD;
          end
        end
        S_BUILD: begin
          // One (length, symbol) pair per cycle yields canonical symbol order.
          if (len_q[bs_q] == bl_q) begin
            sorted_q[sort_n_q] <= bs_q;
            sort_n_q           <= sort_n_q + 4'd1;
            cnt_q[bl_q]        <= cnt_q[bl_q] + 5'd1;
          end
          bs_q <= bs_q + 4'd1;
          if (bs_q == 4'd15) begin
            if (bl_q == MAX_LEN_4) begin
              code_q    <= '0;
              first_q   <= '0;
              index_q   <= '0;
              cur_len_q <= '0;
              state_q   <= (bits_left_q == '0) ? S_FIN : S_DECODE;
            end else begin
              bl_q <= bl_q + 4'd1;
            end
          end
        end
        S_DECODE: begin
          if (bit_valid) begin
            bits_left_q <= bits_left_d;
            if (hit) begin
              sym_out_q <= sorted_q[sel];
              state_q   <= S_EMIT;
            end else begin
              index_q   <= index_q + cnt_cur[3:0];
              first_q   <= (first_q + CW'(cnt_cur)) << 1;
              code_q    <= code_d << 1;
              cur_len_q <= cur_len_d;
              if (cur_len_d == MAX_LEN_4 || bits_left_d == '0) begin
                err_q   <= 1'b1;
                state_q <= S_FIN;
              end
            end
          end
        end
        S_EMIT: begin
          if (sym_ready) begin
            sym_count_q <= sym_count_q + LEN_W'(1);
            code_q      <= '0;
            first_q     <= '0;
            index_q     <= '0;
            cur_len_q   <= '0;
            state_q     <= (bits_left_q == '0) ? S_FIN : S_DECODE;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bit_ready = (state_q == S_DECODE);
  assign sym_valid = (state_q == S_EMIT);
  assign done      = (state_q == S_FIN);
  assign sym_out   = sym_out_q;
  assign sym_count = sym_count_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: canonical decode, stalls, bad and
// truncated codes, empty stream, mid-session reset and ignored writes.
module tb_huffman_decoder;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BUILD = 3'd1;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_sym = '0;
  logic [3:0]  tbl_len = '0;
  logic        start = 1'b0;
  logic [10:0] length = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [3:0]  sym_out;
  logic        sym_valid;
  logic        sym_ready = 1'b0;
  logic [10:0] sym_count;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  huffman_decoder #(.MAX_LEN(15), .LEN_W(11)) dut (
    .CLK(CLK), .nRST(nRST), .tbl_we(tbl_we), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
    .start(start), .length(length), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_count(sym_count), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int done_cnt, build_cycles, br_seen, viol, stab, first_cons, first_sv;

  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b0; tbl_we = 1'b0; start = 1'b0; bit_valid = 1'b0; sym_ready = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic load_len(input logic [3:0] s, input logic [3:0] l);
    @(posedge CLK); #1;
    tbl_we = 1'b1; tbl_sym = s; tbl_len = l;
    @(posedge CLK); #1;
    tbl_we = 1'b0;
  endtask

  task automatic load_t1();
    load_len(4'd0, 4'd1);
    load_len(4'd1, 4'd2);
    load_len(4'd2, 4'd3);
    load_len(4'd3, 4'd3);
  endtask

  // Drives one session; returns after done (+2 cycles), timeout, or once
  // abort_after bits have been consumed (abort_after >= 0).
  task automatic run_session(input logic [10:0] len, input logic [31:0] bits,
                             input int nbits, input bit stall, input bit garbage,
                             input int abort_after);
    int idx, cyc, post, stall_cnt;
    bit cons, done_seen, prev_hold, running;
    logic [3:0] prev_sym;
    got_q.delete();
    done_cnt = 0; build_cycles = 0; br_seen = 0; viol = 0; stab = 0;
    first_cons = -1; first_sv = -1;
    idx = 0; cyc = 0; post = 0; stall_cnt = 0;
    cons = 0; done_seen = 0; prev_hold = 0; prev_sym = '0; running = 1;
    @(posedge CLK); #1;
    start = 1'b1; length = len;
    @(posedge CLK); #1;
    start = 1'b0;
    while (running) begin
      if (cons) idx++;
      if (dbg_state === ST_BUILD) build_cycles++;
      if (bit_ready) br_seen++;
      if (bit_ready && sym_valid) viol++;
      if (prev_hold && (sym_valid !== 1'b1 || sym_out !== prev_sym)) stab++;
      if (sym_valid && first_sv < 0) first_sv = cyc;
      if (done) done_cnt++;
      if (abort_after >= 0 && idx == abort_after) begin
        running = 0;
      end else begin
        if (!stall) sym_ready = 1'b1;
        else if (sym_valid) begin stall_cnt++; sym_ready = (stall_cnt > 5); end
        else begin stall_cnt = 0; sym_ready = 1'b0; end
        bit_valid = (idx < nbits) && (!stall || (cyc % 2 == 0));
        bit_in = bit_valid ? bits[nbits-1-idx] : 1'b0;
        cons = bit_valid && bit_ready;
        if (cons && first_cons < 0) first_cons = cyc;
        if (sym_valid && sym_ready) got_q.push_back(sym_out);
        prev_hold = sym_valid && !sym_ready;
        prev_sym = sym_out;
        if (done) done_seen = 1;
        tbl_we = garbage && !done_seen; tbl_sym = 4'd0; tbl_len = 4'd4;
        start = garbage && !done_seen;
        if (done_seen) post++;
        if (post == 3) running = 0;
        cyc++;
        if (cyc > 3000) begin
          n_checks++; n_fail++;
          $display("FAIL session_timeout: no done after %0d cycles", cyc);
          running = 0;
        end
        if (running) begin @(posedge CLK); #1; end
      end
    end
    bit_valid = 1'b0; sym_ready = 1'b0; tbl_we = 1'b0; start = 1'b0;
  endtask

  task automatic check_syms(input string name);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL %s_nsyms: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL %s_sym%0d: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_end(input string name, input int exp_cnt, input logic exp_err);
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done: pulses %0d expected 1", name, done_cnt); end
    n_checks++;
    if (sym_count !== 11'(exp_cnt)) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, sym_count, exp_cnt); end
    n_checks++;
    if (err !== exp_err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", name, err, exp_err); end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL %s_idle: state %0d expected 0", name, dbg_state); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bit_ready, sym_valid, done, err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bit_ready, sym_valid, done, err});
    end
    n_checks++;
    if (sym_count !== 11'd0 || sym_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_data: count %0d sym %0d expected 0 0", sym_count, sym_out);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_basic(input bit garbage, input string name);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_session(11'd9, 32'b010110111, 9, 1'b0, garbage, -1);
    check_syms(name);
    check_end(name, 4, 1'b0);
    n_checks++;
    if (build_cycles !== 240) begin n_fail++; $display("FAIL %s_build: got %0d cycles expected 240", name, build_cycles); end
    n_checks++;
    if (first_sv - first_cons !== 1) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected 1", name, first_sv - first_cons);
    end
  endtask

  task automatic test_stall();
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    run_session(11'd9, 32'b010110111, 9, 1'b1, 1'b0, -1);
    check_syms("stall");
    check_end("stall", 4, 1'b0);
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL stall_ready_overlap: got %0d expected 0", viol); end
    n_checks++;
    if (stab !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stab); end
  endtask

  task automatic test_bad_code();
    do_reset();
    load_len(4'd5, 4'd1);
    exp_q.delete();
    run_session(11'd1, 32'b1, 1, 1'b0, 1'b0, -1);
    check_syms("badcode");
    check_end("badcode", 0, 1'b1);
  endtask

  task automatic test_truncated();
    do_reset();
    load_t1();
    exp_q.delete();
    run_session(11'd2, 32'b11, 2, 1'b0, 1'b0, -1);
    check_syms("trunc");
    check_end("trunc", 0, 1'b1);
  endtask

  task automatic test_zero_length();
    exp_q.delete();
    run_session(11'd0, 32'b0, 0, 1'b0, 1'b0, -1);
    check_syms("zerolen");
    check_end("zerolen", 0, 1'b0);
    n_checks++;
    if (br_seen !== 0) begin n_fail++; $display("FAIL zerolen_bit_ready: asserted %0d cycles expected 0", br_seen); end
    n_checks++;
    if (build_cycles !== 240) begin n_fail++; $display("FAIL zerolen_build: got %0d expected 240", build_cycles); end
  endtask

  task automatic test_mid_reset();
    int dn;
    run_session(11'd9, 32'b010110111, 9, 1'b0, 1'b0, 4);
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    n_checks++;
    if ({bit_ready, sym_valid, done, err} !== 4'b0 || sym_count !== 11'd0 || sym_out !== 4'd0) begin
      n_fail++; $display("FAIL midreset_outputs: flags %b count %0d sym %0d expected all 0",
                         {bit_ready, sym_valid, done, err}, sym_count, sym_out);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d expected 0", dbg_state); end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (done) dn++;
    end
    n_checks++;
    if (dn !== 0) begin n_fail++; $display("FAIL midreset_done: pulses %0d expected 0", dn); end
    // A cleared table rejects the single bit "0" that sym0=1 would decode.
    exp_q.delete();
    run_session(11'd1, 32'b0, 1, 1'b0, 1'b0, -1);
    check_syms("cleared");
    check_end("cleared", 0, 1'b1);
    load_t1();
    test_basic(1'b1, "ignored_we");
    test_basic(1'b0, "rerun");
  endtask

  initial begin
    test_reset();
    load_t1();
    test_basic(1'b0, "basic");
    test_stall();
    test_zero_length();
    test_bad_code();
    test_truncated();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
